// File: rtl/corr_pkg.sv
// Shared types and constants for the correlator bank reader.
package corr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_CMD,
    ARM,
    SETUP,
    SAMPLE,
    HDR,
    DATA,
    CSUM
  } state_e;

  localparam logic [7:0]  HDR_BYTE = 8'hA5;
  localparam logic [7:0]  RST_ADDR = 8'hFF;
  localparam int unsigned N_CORR   = 8;
  localparam int unsigned N_BYTES  = 16;
  localparam int unsigned IDX_W    = $clog2(N_BYTES);
  localparam int unsigned K_W      = $clog2(N_CORR);

  // Read index i = 2k + b maps to {0000, k, b}; the top nibble stays clear so 0xFF is unreachable.
  function automatic logic [7:0] corr_addr(input logic [IDX_W-1:0] idx);
    logic [K_W-1:0] k;
    logic           b;
    k = idx[IDX_W-1:1];
    b = idx[0];
    return {4'b0000, k, b};
  endfunction

endpackage

// File: rtl/corr_reader.sv
// Resets the correlator bank, waits out the capture window, reads 16 bytes and
// streams them as header + data + XOR checksum over a valid/ready interface.
module corr_reader
  import corr_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2056,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned READ_WAIT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  output logic [7:0] addr_out,
  output logic       cs,
  output logic       oe,
  output logic       we,
  input  logic [7:0] data_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam int unsigned RW_EFF   = (READ_WAIT < 1) ? 1 : READ_WAIT;
  localparam int unsigned RST_EFF  = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
  localparam int unsigned WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int unsigned MAX_A    = (WAIT_EFF > RST_EFF) ? WAIT_EFF : RST_EFF;
  localparam int unsigned CNT_MAX  = (MAX_A > RW_EFF) ? MAX_A : RW_EFF;
  localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         addr_q, addr_d;
  logic               rd_en_q, rd_en_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mem_we;
  logic [7:0]         mem_q [N_BYTES];

  logic               hs;
  logic               last_idx;

  assign hs       = tx_valid_q && tx_ready;
  assign last_idx = (idx_q == IDX_W'(N_BYTES - 1));

  // Next state, counters and registered-output targets.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    mem_we     = 1'b0;
    done_d     = 1'b0;
    addr_d     = 8'h00;
    rd_en_d    = 1'b0;
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    busy_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse belongs to the frame just finished.
        if (continuous || (start && !done_q)) begin
          state_d = RST_CMD;
          cnt_d   = '0;
        end
      end
      RST_CMD: begin
        if (cnt_q == CNT_W'(RST_EFF - 1)) begin
          state_d = ARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARM: begin
        if (cnt_q == CNT_W'(WAIT_EFF - 1)) begin
          state_d = SETUP;
          cnt_d   = '0;
          idx_d   = '0;
          csum_d  = 8'h00;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(RW_EFF - 1)) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        mem_we = 1'b1;
        csum_d = csum_q ^ data_in;
        if (last_idx) begin
          state_d = HDR;
          idx_d   = '0;
        end else begin
          state_d = SETUP;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      HDR: begin
        if (hs) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (hs) begin
          if (last_idx) begin
            state_d = CSUM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      CSUM: begin
        if (hs) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = continuous ? RST_CMD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    case (state_d)
      RST_CMD: addr_d = RST_ADDR;
      SETUP, SAMPLE: begin
        addr_d  = corr_addr(idx_d);
        rd_en_d = 1'b1;
      end
      HDR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = HDR_BYTE;
      end
      DATA: begin
        tx_valid_d = 1'b1;
        tx_data_d  = mem_q[idx_d];
      end
      CSUM: begin
        tx_valid_d = 1'b1;
        tx_data_d  = csum_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      csum_q     <= 8'h00;
      addr_q     <= 8'h00;
      rd_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Sample buffer has no reset; it is always fully rewritten before being streamed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= data_in;
    end
  end

  assign addr_out = addr_q;
  assign cs       = rd_en_q;
  assign oe       = rd_en_q;
  assign we       = 1'b0;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_corr_reader.sv
// Scoreboard bench for corr_reader: expected stream bytes are queued by the
// stimulus, a monitor pops and compares them on every handshake.
`timescale 1ns/1ps
module tb_corr_reader;

  logic       clk = 1'b0;
  logic       rst_n, start, continuous, tx_ready;
  logic       cs, oe, we, tx_valid, busy, done;
  logic [7:0] addr_out, data_in, tx_data;

  int checks   = 0;
  int failures = 0;
  int bank_mode = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  corr_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .addr_out(addr_out), .cs(cs), .oe(oe), .we(we), .data_in(data_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  // Bank model: mode 0 returns 0x10+addr, mode 1 returns 0xFF only at address 0x07.
  always_comb begin
    if (bank_mode == 1) data_in = (addr_out == 8'h07) ? 8'hFF : 8'h00;
    else                data_in = 8'h10 + addr_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pop on handshake, hold-while-stalled, done placement.
  logic       prev_pend;
  logic [7:0] prev_data;
  logic       pend_done;
  int         done_count = 0;
  logic [7:0] done_addr;
  logic       done_busy;
  exp_t       mon_e;

  initial begin
    prev_pend = 1'b0;
    pend_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 1'b0;
        pend_done = 1'b0;
      end else begin
        if (pend_done) begin
          chk("done_after_csum", done, 1);
          pend_done = 1'b0;
        end else if (done) begin
          chk("done_spurious", done, 0);
        end
        if (done) begin
          done_count++;
          done_addr = addr_out;
          done_busy = busy;
        end
        if (prev_pend) begin
          chk("tx_valid_hold", tx_valid, 1);
          chk("tx_data_hold", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected actual=0x%0h required=no_byte", tx_data);
          end else begin
            mon_e = sb_q.pop_front();
            chk("tx_byte", tx_data, mon_e.data);
            if (mon_e.last) pend_done = 1'b1;
          end
          prev_pend = 1'b0;
        end else begin
          prev_pend = tx_valid;
          prev_data = tx_data;
        end
      end
    end
  end

  // Bus trace: reset-command cycles, arm cycles, read cycles and read addresses.
  int         ff_cnt, ff_cs_cnt, arm_cnt, cs_cnt, txv_cnt;
  logic [7:0] reads[$];
  logic       prev_cs;
  logic [7:0] prev_addr;

  task automatic clear_trace();
    ff_cnt = 0; ff_cs_cnt = 0; arm_cnt = 0; cs_cnt = 0; txv_cnt = 0;
    reads.delete();
  endtask

  initial begin
    prev_cs = 1'b0;
    prev_addr = 8'h00;
    clear_trace();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (addr_out == 8'hFF) begin
          ff_cnt++;
          if (cs || oe) ff_cs_cnt++;
        end
        if (busy && !cs && !tx_valid && addr_out == 8'h00) arm_cnt++;
        if (cs) begin
          cs_cnt++;
          if (!prev_cs || addr_out != prev_addr) reads.push_back(addr_out);
        end
        if (tx_valid) txv_cnt++;
        prev_cs = cs;
        prev_addr = addr_out;
      end else begin
        prev_cs = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] b [16], input logic [7:0] csum);
    sb_q.push_back('{data: 8'hA5, last: 1'b0});
    for (int i = 0; i < 16; i++) sb_q.push_back('{data: b[i], last: 1'b0});
    sb_q.push_back('{data: csum, last: 1'b1});
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int n;
    n = 0;
    while (done_count <= base && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_count <= base) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, done_count, base + 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, addr_out, 8'h00);
    chk({tag, "_cs"}, cs, 0);
    chk({tag, "_oe"}, oe, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  logic [7:0] fa [16];
  logic [7:0] fc [16];
  int         base, n, hold_ok;

  initial begin
    // Frame A: 0x10..0x1F, XOR = 0x00. Frame C: 0xFF at index 7 only, XOR = 0xFF.
    for (int i = 0; i < 16; i++) begin
      fa[i] = 8'h10 + 8'(i);
      fc[i] = (i == 7) ? 8'hFF : 8'h00;
    end

    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; tx_ready = 1'b0;
    tick(3);
    chk_reset_outputs("rst_hold");
    rst_n = 1'b1;
    tick(2);
    chk_reset_outputs("rst_release");

    // Basic frame with an always-ready sink.
    clear_trace();
    tx_ready = 1'b1;
    push_frame(fa, 8'h00);
    base = done_count;
    pulse_start();
    wait_done(base, 5000, "frame_a");
    chk("a_ff_cycles", ff_cnt, 2);
    chk("a_arm_cycles", arm_cnt, 2056);
    chk("a_read_cycles", cs_cnt, 48);
    chk("a_read_count", reads.size(), 16);
    for (int i = 0; i < 16 && i < reads.size(); i++) chk("a_read_addr", reads[i], i);
    chk("a_tx_valid_cycles", txv_cnt, 18);
    chk("a_done_busy", done_busy, 0);
    chk("a_sb_empty", sb_q.size(), 0);

    // Sink stalls 50 cycles on DATA byte 3.
    clear_trace();
    push_frame(fa, 8'h00);
    base = done_count;
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_valid && tx_data == 8'h12) && n < 5000);
    chk("b_reach_byte2", tx_data, 8'h12);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    hold_ok = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_valid && tx_data == 8'h13) hold_ok++;
    end
    chk("b_stall_hold_cycles", hold_ok, 50);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_done(base, 5000, "frame_b");
    chk("b_sb_empty", sb_q.size(), 0);

    // Single nonzero byte gives a 0xFF checksum.
    clear_trace();
    bank_mode = 1;
    push_frame(fc, 8'hFF);
    base = done_count;
    pulse_start();
    wait_done(base, 5000, "frame_c");
    chk("c_sb_empty", sb_q.size(), 0);
    bank_mode = 0;

    // Continuous mode: back-to-back frames, reset command follows the CSUM handshake.
    clear_trace();
    push_frame(fa, 8'h00);
    push_frame(fa, 8'h00);
    base = done_count;
    continuous = 1'b1;
    wait_done(base, 5000, "cont_first");
    chk("d_done_addr_ff", done_addr, 8'hFF);
    chk("d_done_busy", done_busy, 1);
    continuous = 1'b0;
    wait_done(base + 1, 5000, "cont_second");
    chk("d_ff_cycles", ff_cnt, 4);
    chk("d_ff_during_read", ff_cs_cnt, 0);
    chk("d_read_cycles", cs_cnt, 96);
    chk("d_end_busy", done_busy, 0);
    chk("d_sb_empty", sb_q.size(), 0);

    // Reset asserted while sampling index 9.
    clear_trace();
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cs && addr_out == 8'h09) && n < 5000);
    chk("e_reach_read9", addr_out, 8'h09);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("e_mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_trace();
    tick(3000);
    chk("e_no_tx_after_rst", txv_cnt, 0);
    chk("e_idle_busy", busy, 0);
    chk("e_sb_empty", sb_q.size(), 0);

    // Extra start pulses during ARM and on the done cycle are ignored.
    clear_trace();
    push_frame(fa, 8'h00);
    base = done_count;
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && !cs && !tx_valid && addr_out == 8'h00) && n < 100);
    chk("f_in_arm", busy, 1);
    tick(100);
    pulse_start();
    tick(500);
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 5000);
    chk("f_done_seen", done, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tick(20);
    chk("f_arm_cycles", arm_cnt, 2056);
    chk("f_ff_cycles", ff_cnt, 2);
    chk("f_tx_valid_cycles", txv_cnt, 18);
    chk("f_done_count", done_count, base + 1);
    chk("f_idle_busy", busy, 0);
    chk("f_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
